// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
// funct3 encodings, FSM states and counter width.
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } dmem_state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for RV32I loads/stores.
// Produces byte enables, lane data, extended load data and error.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic        i_we,
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rword,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic [31:0] o_rdata,
   output logic        o_err
);

   logic [31:0] w_bsh;
   logic [31:0] w_hsh;

   assign w_bsh = i_rword >> {i_addr_lo, 3'b000};
   assign w_hsh = i_rword >> {i_addr_lo[1], 4'b0000};

   // Decode width, steer lanes and flag misaligned/reserved accesses
   always_comb begin
      o_be    = 4'b0000;
      o_wdata = 32'd0;
      o_rdata = 32'd0;
      o_err   = 1'b0;
      if (i_we) begin
         case (i_funct3)
            F3_B: begin
               o_be    = 4'b0001 << i_addr_lo;
               o_wdata = {4{i_wdata[7:0]}};
            end
            F3_H: begin
               o_err   = i_addr_lo[0];
               o_be    = 4'b0011 << {i_addr_lo[1], 1'b0};
               o_wdata = {2{i_wdata[15:0]}};
            end
            F3_W: begin
               o_err   = (i_addr_lo != 2'b00);
               o_be    = 4'b1111;
               o_wdata = i_wdata;
            end
            default: o_err = 1'b1;
         endcase
         if (o_err) o_be = 4'b0000;
      end else begin
         case (i_funct3)
            F3_B:  o_rdata = {{24{w_bsh[7]}}, w_bsh[7:0]};
            F3_BU: o_rdata = {24'd0, w_bsh[7:0]};
            F3_H: begin
               o_err   = i_addr_lo[0];
               o_rdata = {{16{w_hsh[15]}}, w_hsh[15:0]};
            end
            F3_HU: begin
               o_err   = i_addr_lo[0];
               o_rdata = {16'd0, w_hsh[15:0]};
            end
            F3_W: begin
               o_err   = (i_addr_lo != 2'b00);
               o_rdata = i_rword;
            end
            default: o_err = 1'b1;
         endcase
         if (o_err) o_rdata = 32'd0;
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder with valid/ready handshake.
// One outstanding request; busy_o stalls the pipeline.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 8,
   parameter int DATA_WIDTH    = 32,
   parameter int LATENCY       = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid_i,
   output logic                     req_ready_o,
   input  logic                     req_we_i,
   input  logic [2:0]               req_funct3_i,
   input  logic [ADDRESS_WIDTH-1:0] req_addr_i,
   input  logic [DATA_WIDTH-1:0]    req_wdata_i,
   output logic                     rsp_valid_o,
   input  logic                     rsp_ready_i,
   output logic [DATA_WIDTH-1:0]    rsp_rdata_o,
   output logic                     rsp_err_o,
   output logic                     busy_o
);

   localparam int DEPTH = 1 << ADDRESS_WIDTH;
   localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

   dmem_state_t              r_state;
   logic [CNT_W-1:0]         r_cnt;
   logic                     r_we;
   logic [2:0]               r_f3;
   logic [ADDRESS_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0]    r_wdata;
   logic                     r_ready;
   logic                     r_valid;
   logic                     r_busy;
   logic [DATA_WIDTH-1:0]    r_rdata;
   logic                     r_err;
   logic [7:0]               r_mem [0:DEPTH-1] = '{default: 8'd0};

   logic                     w_idle;
   logic                     w_we;
   logic [2:0]               w_f3;
   logic [ADDRESS_WIDTH-1:0] w_addr;
   logic [DATA_WIDTH-1:0]    w_wdata;
   logic [ADDRESS_WIDTH-3:0] w_wa;
   logic [31:0]              w_rword;
   logic [3:0]               w_be;
   logic [31:0]              w_wdata_sh;
   logic [31:0]              w_rdata_ext;
   logic                     w_err;
   logic                     w_enter_resp;

   // With LATENCY=1 the access happens on the accepting edge,
   // so the live request is used instead of the latched copy.
   assign w_idle  = (r_state == IDLE);
   assign w_we    = w_idle ? req_we_i     : r_we;
   assign w_f3    = w_idle ? req_funct3_i : r_f3;
   assign w_addr  = w_idle ? req_addr_i   : r_addr;
   assign w_wdata = w_idle ? req_wdata_i  : r_wdata;
   assign w_wa    = w_addr[ADDRESS_WIDTH-1:2];

   assign w_rword = {r_mem[{w_wa, 2'd3}], r_mem[{w_wa, 2'd2}],
                     r_mem[{w_wa, 2'd1}], r_mem[{w_wa, 2'd0}]};

   assign w_enter_resp = ~rst &
      ((w_idle & req_valid_i & (LATENCY == 1)) |
       ((r_state == WAIT) & (r_cnt == CNT_W'(1))));

   dmem_lane_align u_align (
      .i_we      (w_we),
      .i_funct3  (w_f3),
      .i_addr_lo (w_addr[1:0]),
      .i_wdata   (w_wdata),
      .i_rword   (w_rword),
      .o_be      (w_be),
      .o_wdata   (w_wdata_sh),
      .o_rdata   (w_rdata_ext),
      .o_err     (w_err)
   );

   // Commit enabled byte lanes on the edge that enters RESP
   always_ff @(posedge clk) begin
      if (w_enter_resp) begin
         for (int k = 0; k < 4; k++) begin
            if (w_be[k]) r_mem[{w_wa, k[1:0]}] <= w_wdata_sh[8*k +: 8];
         end
      end
   end

   // Request/response FSM with registered handshake outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_we    <= 1'b0;
         r_f3    <= 3'd0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_ready <= 1'b1;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (req_valid_i) begin
                  r_we    <= req_we_i;
                  r_f3    <= req_funct3_i;
                  r_addr  <= req_addr_i;
                  r_wdata <= req_wdata_i;
                  r_ready <= 1'b0;
                  r_busy  <= 1'b1;
                  if (LATENCY == 1) begin
                     r_state <= RESP;
                     r_cnt   <= '0;
                     r_valid <= 1'b1;
                     r_rdata <= w_rdata_ext;
                     r_err   <= w_err;
                  end else begin
                     r_state <= WAIT;
                     r_cnt   <= LAT_M1;
                  end
               end
            end
            WAIT: begin
               r_cnt <= r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) begin
                  r_state <= RESP;
                  r_valid <= 1'b1;
                  r_rdata <= w_rdata_ext;
                  r_err   <= w_err;
               end
            end
            RESP: begin
               if (rsp_ready_i) begin
                  r_state <= IDLE;
                  r_valid <= 1'b0;
                  r_busy  <= 1'b0;
                  r_ready <= 1'b1;
                  r_rdata <= '0;
                  r_err   <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign req_ready_o = r_ready;
   assign rsp_valid_o = r_valid;
   assign rsp_rdata_o = r_rdata;
   assign rsp_err_o   = r_err;
   assign busy_o      = r_busy;

endmodule
